bram_tdp_req_arbiter: RTL

Shares one single-clock true-dual-port write-first BRAM between NUM_REQ requesters. Each cycle it grants up to two requests round-robin, one to port A and one to port B, and drives the RAM ports. It tracks reads in flight through the RAM's fixed read latency and returns each response to the requester that issued it. It also blocks same-cycle cross-port address collisions, which the RAM leaves undefined.

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/bram_arb_rr_pick.sv | 45 ++++
 rtl/bram_tdp_req_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and helpers for
// the true-dual-port BRAM request arbiter.
package bram_arb_pkg;

  localparam int ID_W = 4;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } inflight_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/bram_arb_rr_pick.sv
// bram_arb_rr_pick: picks the first two valid
// requesters scanning upward from ptr.
module bram_arb_rr_pick
  import bram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  coll [N],
  output logic [PW-1:0] f,
  output logic [PW-1:0] s,
  output logic          f_vld,
  output logic          s_vld
);

  logic [PW-1:0] idx;
  logic          f_hit;
  logic          s_hit;

  always_comb begin
    f     = '0;
    s     = '0;
    f_hit = 1'b0;
    s_hit = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (valid[idx]) begin
        if (!f_hit) begin
          f_hit = 1'b1;
          f     = idx;
        end else if (!s_hit) begin
          s_hit = 1'b1;
          s     = idx;
        end
      end
    end
    f_vld = f_hit;
    // only the runner-up is considered for B
    s_vld = s_hit && !coll[f][s];
  end

endmodule

// File: rtl/bram_tdp_req_arbiter.sv
// bram_tdp_req_arbiter: shares one write-first TDP
// BRAM between NUM_REQ requesters, two grants/cycle.
module bram_tdp_req_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
  output logic                      ram_ena,
  output logic                      ram_enb,
  output logic                      ram_wea,
  output logic                      ram_web,
  output logic [ADDR_W-1:0]         ram_addra,
  output logic [ADDR_W-1:0]         ram_addrb,
  output logic [DATA_W-1:0]         ram_dina,
  output logic [DATA_W-1:0]         ram_dinb,
  output logic                      ram_regcea,
  output logic                      ram_regceb,
  output logic                      ram_rsta,
  output logic                      ram_rstb,
  input  logic [DATA_W-1:0]         ram_douta,
  input  logic [DATA_W-1:0]         ram_doutb
);

  localparam int PW = clog2(NUM_REQ);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_n
    $error("NUM_REQ must be 2..16");
  end

  logic [ADDR_W-1:0]  addr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata [NUM_REQ];
  logic [NUM_REQ-1:0] coll  [NUM_REQ];
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      f;
  logic [PW-1:0]      s;
  logic               f_vld;
  logic               s_vld;
  logic               f_g;
  logic               s_g;
  inflight_t          pipe_a [RD_LAT];
  inflight_t          pipe_b [RD_LAT];
  inflight_t          last_a;
  inflight_t          last_b;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] i
  );
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    end
    // cross-port same address is undefined unless both read
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        coll[i][j] = (i != j)
          && (addr[i] == addr[j])
          && (req_we[i] || req_we[j]);
      end
    end
  end

  bram_arb_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .coll  (coll),
    .f     (f),
    .s     (s),
    .f_vld (f_vld),
    .s_vld (s_vld)
  );

  assign f_g = f_vld && !rst;
  assign s_g = s_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (f_g) req_ready[f] = 1'b1;
    if (s_g) req_ready[s] = 1'b1;
  end

  assign ram_ena    = f_g;
  assign ram_wea    = f_g && req_we[f];
  assign ram_addra  = addr[f];
  assign ram_dina   = wdata[f];
  assign ram_enb    = s_g;
  assign ram_web    = s_g && req_we[s];
  assign ram_addrb  = addr[s];
  assign ram_dinb   = wdata[s];
  assign ram_regcea = 1'b1;
  assign ram_regceb = 1'b1;
  assign ram_rsta   = rst;
  assign ram_rstb   = rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (s_g) begin
      ptr <= nxt(s);
    end else if (f_g) begin
      ptr <= nxt(f);
    end
  end

  // one stage per RAM read-latency cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      pipe_a[0].valid <= f_g;
      pipe_a[0].id    <= ID_W'(f);
      pipe_b[0].valid <= s_g;
      pipe_b[0].id    <= ID_W'(s);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign last_a = pipe_a[RD_LAT-1];
  assign last_b = pipe_b[RD_LAT-1];

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (last_a.valid && int'(last_a.id) == k) begin
        rsp_valid[k]                  = 1'b1;
        rsp_rdata[k*DATA_W +: DATA_W] = ram_douta;
      end
      if (last_b.valid && int'(last_b.id) == k) begin
        rsp_valid[k]                  = 1'b1;
        rsp_rdata[k*DATA_W +: DATA_W] = ram_doutb;
      end
    end
  end

endmodule
